// File: rtl/branch_control.sv
// branch_control: turns the registered Z/N flags into a conditional-branch
// decision for the PC. A request (opcode + target) is latched in IDLE, any
// in-flight flags write is waited out, the condition is evaluated once, and
// branch_ack / pc_load are pulsed for a single cycle.
//
// Optional feature: define BRANCH_COUNT_EN to build a wrapping counter of
// taken branches, exposed on the branch_count port. Without the macro the
// port and counter are absent and behaviour is otherwise identical.
module branch_control #(
   parameter int unsigned ADDR_WIDTH  = 11,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   branch_reset,
   input  logic                   branch_req,
   input  logic [2:0]             branch_op,
   input  logic [ADDR_WIDTH-1:0]  branch_target,
   input  logic                   flag_Z,
   input  logic                   flag_N,
   input  logic                   flags_wr,
   output logic                   branch_busy,
   output logic                   branch_ack,
   output logic                   pc_load,
   output logic                   branch_taken,
   output logic [ADDR_WIDTH-1:0]  pc_target
`ifdef BRANCH_COUNT_EN
   ,
   output logic [COUNT_WIDTH-1:0] branch_count
`endif
);

   // Elaboration-time sanity check on the configuration.
   if (ADDR_WIDTH < 1 || COUNT_WIDTH < 1) begin : g_bad_param
      $error("branch_control: ADDR_WIDTH and COUNT_WIDTH must be at least 1");
   end

   // Condition codes carried by branch_op.
   typedef enum logic [2:0] {
      OpJmp = 3'b000,
      OpBeq = 3'b001,
      OpBne = 3'b010,
      OpBgt = 3'b011,
      OpBge = 3'b100,
      OpBlt = 3'b101,
      OpBle = 3'b110,
      OpNop = 3'b111
   } branch_op_t;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StEval,
      StDone
   } state_t;

   state_t     state_q;
   branch_op_t op_q;
   logic       cond;

   // Branch condition from the latched opcode and the live flags; only
   // consumed in EVAL, so flag movement while waiting is naturally tracked.
   always_comb begin
      cond = 1'b0;
      unique case (op_q)
         OpJmp:   cond = 1'b1;
         OpBeq:   cond = flag_Z;
         OpBne:   cond = ~flag_Z;
         OpBgt:   cond = ~flag_Z & ~flag_N;
         OpBge:   cond = ~flag_N;
         OpBlt:   cond = flag_N;
         OpBle:   cond = flag_N | flag_Z;
         OpNop:   cond = 1'b0;
         default: cond = 1'b0;
      endcase
   end

   // Control FSM with all outputs registered alongside the state.
   always_ff @(posedge clock or posedge branch_reset) begin
      if (branch_reset) begin
         state_q      <= StIdle;
         op_q         <= OpJmp;
         pc_target    <= '0;
         branch_busy  <= 1'b0;
         branch_ack   <= 1'b0;
         pc_load      <= 1'b0;
         branch_taken <= 1'b0;
`ifdef BRANCH_COUNT_EN
         branch_count <= '0;
`endif
      end else begin
         // ack/pc_load are single-cycle pulses; only EVAL raises them.
         branch_ack <= 1'b0;
         pc_load    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (branch_req) begin
                  op_q        <= branch_op_t'(branch_op);
                  pc_target   <= branch_target;
                  branch_busy <= 1'b1;
                  // A flags write on the request edge has not landed yet.
                  state_q     <= flags_wr ? StWait : StEval;
               end
            end
            StWait: begin
               if (!flags_wr) begin
                  state_q <= StEval;
               end
            end
            StEval: begin
               branch_taken <= cond;
               branch_ack   <= 1'b1;
               pc_load      <= cond;
               state_q      <= StDone;
`ifdef BRANCH_COUNT_EN
               if (cond) begin
                  branch_count <= branch_count + 1'b1;
               end
`endif
            end
            StDone: begin
               // Requests are ignored here; a held request is taken in IDLE.
               branch_busy <= 1'b0;
               state_q     <= StIdle;
            end
            default: begin
               branch_busy <= 1'b0;
               state_q     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_control.sv
// Self-checking bench for branch_control: directed condition/latency cases
// plus randomized branches against a behavioural model of the decision rules.
module tb_branch_control;

   localparam int unsigned AW = 11;
   localparam int unsigned CW = 2;

   logic          clock = 1'b0;
   logic          branch_reset;
   logic          branch_req;
   logic [2:0]    branch_op;
   logic [AW-1:0] branch_target;
   logic          flag_Z;
   logic          flag_N;
   logic          flags_wr;
   logic          branch_busy;
   logic          branch_ack;
   logic          pc_load;
   logic          branch_taken;
   logic [AW-1:0] pc_target;
`ifdef BRANCH_COUNT_EN
   logic [CW-1:0] branch_count;
`endif

   int nchecks = 0;
   int nfail   = 0;
   int cnt_model = 0;
   logic taken_model = 1'b0;

   branch_control #(
      .ADDR_WIDTH (AW),
      .COUNT_WIDTH(CW)
   ) dut (
      .clock        (clock),
      .branch_reset (branch_reset),
      .branch_req   (branch_req),
      .branch_op    (branch_op),
      .branch_target(branch_target),
      .flag_Z       (flag_Z),
      .flag_N       (flag_N),
      .flags_wr     (flags_wr),
      .branch_busy  (branch_busy),
      .branch_ack   (branch_ack),
      .pc_load      (pc_load),
      .branch_taken (branch_taken),
      .pc_target    (pc_target)
`ifdef BRANCH_COUNT_EN
      ,
      .branch_count (branch_count)
`endif
   );

   always #5 clock = ~clock;

   // Decision rules straight from the condition-code table.
   function automatic logic ref_cond(input logic [2:0] op, input logic z, input logic n);
      int zi = int'(z);
      int ni = int'(n);
      case (op)
         3'd0:    return 1'b1;
         3'd1:    return zi == 1;
         3'd2:    return zi == 0;
         3'd3:    return (zi + ni) == 0;
         3'd4:    return ni == 0;
         3'd5:    return ni == 1;
         3'd6:    return (zi + ni) > 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One complete branch: request, h cycles of flags_wr, then decision.
   // Flags differ from the final values until the EVAL edge.
   task automatic run_branch(input logic [2:0] op, input logic [AW-1:0] tgt, input int h,
                             input logic fz, input logic fn, input string name);
      logic exp;
      branch_req    = 1'b1;
      branch_op     = op;
      branch_target = tgt;
      flags_wr      = (h > 0);
      flag_Z        = ~fz;
      flag_N        = ~fn;
      step();
      branch_req    = 1'b0;
      branch_op     = 3'($urandom);
      branch_target = AW'($urandom);
      nchecks++;
      if (branch_busy !== 1'b1 || branch_ack !== 1'b0 || pc_target !== tgt) begin
         nfail++;
         $display("FAIL %s accept: busy=%b ack=%b tgt=%h, want busy=1 ack=0 tgt=%h",
                  name, branch_busy, branch_ack, pc_target, tgt);
      end
      for (int k = 1; k <= h; k++) begin
         flags_wr = (k < h);
         flag_Z   = ~fz;
         flag_N   = 1'($urandom);
         step();
         nchecks++;
         if (branch_ack !== 1'b0 || branch_busy !== 1'b1) begin
            nfail++;
            $display("FAIL %s wait%0d: ack=%b busy=%b, want ack=0 busy=1",
                     name, k, branch_ack, branch_busy);
         end
      end
      flags_wr = 1'b0;
      flag_Z   = fz;
      flag_N   = fn;
      exp      = ref_cond(op, fz, fn);
      step();
      taken_model = exp;
      if (exp) cnt_model = (cnt_model + 1) % (1 << CW);
      nchecks++;
      if (branch_ack !== 1'b1 || pc_load !== exp || branch_taken !== exp ||
          branch_busy !== 1'b1 || pc_target !== tgt) begin
         nfail++;
         $display("FAIL %s decide: ack=%b load=%b taken=%b busy=%b tgt=%h, want 1 %b %b 1 %h",
                  name, branch_ack, pc_load, branch_taken, branch_busy, pc_target,
                  exp, exp, tgt);
      end
`ifdef BRANCH_COUNT_EN
      nchecks++;
      if (int'(branch_count) !== cnt_model) begin
         nfail++;
         $display("FAIL %s count: got %0d want %0d", name, branch_count, cnt_model);
      end
`endif
      step();
      nchecks++;
      if (branch_ack !== 1'b0 || pc_load !== 1'b0 || branch_busy !== 1'b0 ||
          branch_taken !== exp) begin
         nfail++;
         $display("FAIL %s done: ack=%b load=%b busy=%b taken=%b, want 0 0 0 %b",
                  name, branch_ack, pc_load, branch_busy, branch_taken, exp);
      end
   endtask

   task automatic test_reset();
      branch_reset  = 1'b1;
      branch_req    = 1'b0;
      branch_op     = 3'd0;
      branch_target = '0;
      flag_Z        = 1'b0;
      flag_N        = 1'b0;
      flags_wr      = 1'b0;
      step();
      step();
      nchecks++;
      if (branch_busy !== 1'b0 || branch_ack !== 1'b0 || pc_load !== 1'b0 ||
          branch_taken !== 1'b0 || pc_target !== '0) begin
         nfail++;
         $display("FAIL reset: busy=%b ack=%b load=%b taken=%b tgt=%h, want all 0",
                  branch_busy, branch_ack, pc_load, branch_taken, pc_target);
      end
`ifdef BRANCH_COUNT_EN
      nchecks++;
      if (branch_count !== '0) begin
         nfail++;
         $display("FAIL reset_count: got %0d want 0", branch_count);
      end
`endif
      branch_reset = 1'b0;
      step();
   endtask

   task automatic test_jmp();
      run_branch(3'd0, 11'h155, 0, 1'b0, 1'b0, "jmp");
   endtask

   task automatic test_cond_table();
      for (int op = 1; op <= 6; op++) begin
         for (int zn = 0; zn < 4; zn++) begin
            run_branch(3'(op), AW'($urandom), 0, zn[1], zn[0], "cond_table");
         end
      end
   endtask

   task automatic test_hazard();
      run_branch(3'd1, 11'h2a3, 2, 1'b1, 1'b0, "hazard_beq");
   endtask

   task automatic test_nop();
      run_branch(3'd7, 11'h7ff, 0, 1'b1, 1'b1, "nop");
   endtask

   task automatic test_reset_mid();
      branch_req    = 1'b1;
      branch_op     = 3'd0;
      branch_target = 11'h3c3;
      flags_wr      = 1'b1;
      step();
      branch_req = 1'b0;
      step();
      #2;
      branch_reset = 1'b1;
      #1;
      cnt_model   = 0;
      taken_model = 1'b0;
      nchecks++;
      if (branch_busy !== 1'b0 || branch_ack !== 1'b0 || pc_load !== 1'b0 ||
          branch_taken !== 1'b0 || pc_target !== '0) begin
         nfail++;
         $display("FAIL reset_mid: busy=%b ack=%b load=%b taken=%b tgt=%h, want all 0",
                  branch_busy, branch_ack, pc_load, branch_taken, pc_target);
      end
      @(posedge clock);
      #1;
      branch_reset = 1'b0;
      flags_wr     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         nchecks++;
         if (branch_ack !== 1'b0 || branch_busy !== 1'b0 || pc_load !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mid_idle%0d: ack=%b busy=%b load=%b, want 0 0 0",
                     i, branch_ack, branch_busy, pc_load);
         end
      end
      run_branch(3'd2, 11'h0f0, 1, 1'b0, 1'b1, "after_reset");
   endtask

   task automatic test_back_to_back();
      branch_req    = 1'b1;
      branch_op     = 3'd0;
      branch_target = 11'h111;
      flags_wr      = 1'b0;
      step();
      step();
      cnt_model = (cnt_model + 1) % (1 << CW);
      nchecks++;
      if (branch_ack !== 1'b1 || pc_load !== 1'b1) begin
         nfail++;
         $display("FAIL b2b_first: ack=%b load=%b, want 1 1", branch_ack, pc_load);
      end
      branch_target = 11'h222;
      step();
      nchecks++;
      if (branch_busy !== 1'b0 || branch_ack !== 1'b0 || pc_target !== 11'h111) begin
         nfail++;
         $display("FAIL b2b_done: busy=%b ack=%b tgt=%h, want 0 0 111",
                  branch_busy, branch_ack, pc_target);
      end
      step();
      branch_req = 1'b0;
      nchecks++;
      if (branch_busy !== 1'b1 || pc_target !== 11'h222) begin
         nfail++;
         $display("FAIL b2b_reaccept: busy=%b tgt=%h, want 1 222", branch_busy, pc_target);
      end
      step();
      cnt_model = (cnt_model + 1) % (1 << CW);
      nchecks++;
      if (branch_ack !== 1'b1 || pc_load !== 1'b1) begin
         nfail++;
         $display("FAIL b2b_second: ack=%b load=%b, want 1 1", branch_ack, pc_load);
      end
`ifdef BRANCH_COUNT_EN
      nchecks++;
      if (int'(branch_count) !== cnt_model) begin
         nfail++;
         $display("FAIL b2b_count: got %0d want %0d", branch_count, cnt_model);
      end
`endif
      step();
   endtask

   task automatic test_count_wrap();
      for (int i = 0; i < 5; i++) begin
         run_branch(3'd0, AW'($urandom), 0, 1'($urandom), 1'($urandom), "count_wrap");
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_branch(3'($urandom), AW'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_jmp();
      test_cond_table();
      test_hazard();
      test_nop();
      test_reset_mid();
      test_count_wrap();
      test_back_to_back();
      test_random();
      nchecks++;
      if (branch_taken !== taken_model) begin
         nfail++;
         $display("FAIL taken_hold: got %b want %b", branch_taken, taken_model);
      end
      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule
